load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage controller that sits directly upstream of the word-addressed data RAM. It accepts one load or store request at a time from the pipeline MEM stage and converts byte addresses to word indices. Sub-word stores are performed as read-modify-write. Load data is extracted and sign- or zero-extended. Because the RAM acts on enable rising edges, the block drives every enable as a registered one-cycle pulse.

Parameters:
MEM_SIZE, 32, number of 32-bit words in the data RAM; word indices >= MEM_SIZE are out of range.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  qualified by resp_valid; misaligned, out of range, or reserved size
mem_addr  output  32  word index = req_addr[31:2], zero-extended
mem_wdata  output  32  word written to RAM
mem_we  output  1  RAM write enable, one-cycle pulse
mem_re  output  1  RAM read enable, one-cycle pulse
mem_rdata  input  32  RAM read data

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- Reset takes effect at the next clk edge from any state. It aborts any access in progress.
- If reset lands between RD and WR of a read-modify-write, no write is issued and the RAM word is unchanged.
- Handshake: a request is accepted on a clk edge where req_valid=1 and req_ready=1.
- On acceptance, all request fields are latched. Inputs are ignored while the block is busy.
- Responses are single-cycle pulses with no backpressure.
- States: IDLE, RD, WR, DONE. Every access passes through DONE and then IDLE, so mem_re and mem_we always return low between accesses and each access produces a fresh rising edge at the RAM.
- Errors are checked at acceptance:
  - word index >= MEM_SIZE;
  - req_size=11;
  - misalignment when alignment checking is enabled: halfword with addr[0]=1, or word with addr[1:0]!=00.
- Error path: IDLE -> DONE with resp_err=1. No RAM enable is asserted. resp_valid rises 1 cycle after acceptance.
- Load: IDLE -> RD (mem_re=1) -> DONE.
  - mem_rdata is captured on the RD->DONE edge.
  - resp_valid rises 2 cycles after acceptance.
- Word store: IDLE -> WR (mem_we=1, mem_wdata=req_wdata) -> DONE. resp_valid rises 2 cycles after acceptance.
- Byte or halfword store: IDLE -> RD -> WR -> DONE. resp_valid rises 3 cycles after acceptance.
  - mem_wdata = captured word with the target lane replaced by req_wdata[7:0] or req_wdata[15:0].
  - All other lanes are preserved.
- Byte order is little-endian:
  - byte lane n = bits [8n+7:8n], selected by addr[1:0];
  - halfword lane = addr[1] (bits [15:0] or [31:16]).
- Load extension: byte/halfword loads are sign-extended from bit 7/15, or zero-extended when req_unsigned=1. Word loads are passed through.
- mem_addr holds the latched word index from acceptance until the next acceptance.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined: misaligned halfword or word accesses complete with resp_err=1 and do not touch the RAM.
- Undefined: no misalignment error. Low address bits are ignored:
  - halfword uses addr[1] only (addr[0] dropped);
  - word ignores addr[1:0].
- Range and reserved-size errors are reported in both builds.

Test Plan:
1. Reset asserted mid-RD of a load -> next cycle req_ready=1, mem_re=0, resp_valid never pulses for the aborted request.
2. Store word 0xDEADBEEF at addr 0x8, then load word at 0x8 -> mem_we pulse with mem_addr=2; load resp_valid 2 cycles after acceptance, resp_rdata=0xDEADBEEF, resp_err=0.
3. With word 2 = 0xDEADBEEF, store byte 0x5A at addr 0x9 -> RD, WR, DONE sequence; mem_wdata=0xDEAD5AEF; resp_valid 3 cycles after acceptance.
4. Load byte at 0xB, signed -> 0xFFFFFFDE; same with req_unsigned=1 -> 0x000000DE; load halfword at 0xA, signed -> 0xFFFFDEAD.
5. Load word at addr 0x80 with MEM_SIZE=32 -> resp_err=1 one cycle after acceptance, resp_rdata=0, no mem_re/mem_we pulse; same for req_size=11.
6. Load word at addr 0x6:
   - with LSU_ALIGN_CHECK_EN: resp_err=1, no RAM access;
   - without it: mem_addr=1, data returned from word 1, resp_err=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-RAM signal bundle for load_store_unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    // master: pipeline MEM stage plus data RAM surrounding the unit
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store controller with RMW sub-word stores; LSU_ALIGN_CHECK_EN enables misalignment errors
module load_store_unit #(
    parameter int MEM_SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);

    state_t      state_q, state_d;
    logic        we_q, uns_q;
    logic [1:0]  size_q, lane_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic accept, req_err, err_range, err_size, err_align;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        if (size == 2'b00) begin
            case (lane)
                2'd0:    r[7:0]   = wdata[7:0];
                2'd1:    r[15:8]  = wdata[7:0];
                2'd2:    r[23:16] = wdata[7:0];
                default: r[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            r[31:16] = wdata[15:0];
        end else begin
            r[15:0] = wdata[15:0];
        end
        return r;
    endfunction

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign err_range = (bus.req_addr[31:2] >= MEM_WORDS);
    assign err_size  = (bus.req_size == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
    assign err_align = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign err_align = 1'b0;
`endif
    assign req_err   = err_range || err_size || err_align;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)                   state_d = DONE;
                    else if (!bus.req_we)          state_d = RD;
                    else if (bus.req_size == 2'b10) state_d = WR;
                    else                           state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : DONE;
            WR:      state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so every enable leaves a flop as a clean pulse
    always_comb begin
        mem_re_d     = (state_d == RD);
        mem_we_d     = (state_d == WR);
        resp_valid_d = (state_d == DONE);
        resp_err_d   = (state_q == IDLE) && (state_d == DONE);
        resp_rdata_d = '0;
        if (state_q == RD && state_d == DONE)
            resp_rdata_d = load_extend(bus.mem_rdata, size_q, lane_q, uns_q);
        mem_wdata_d = mem_wdata_q;
        if (state_q == IDLE && state_d == WR)
            mem_wdata_d = bus.req_wdata;
        else if (state_q == RD && state_d == WR)
            mem_wdata_d = store_merge(bus.mem_rdata, wdata_q, size_q, lane_q);
        mem_addr_d = accept ? {2'b00, bus.req_addr[31:2]} : mem_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                lane_q  <= bus.req_addr[1:0];
                wdata_q <= bus.req_wdata;
            end
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with an edge-triggered RAM model
module tb_load_store_unit;

    logic clk;
    logic reset;
    load_store_unit_if bus ();

    load_store_unit #(.MEM_SIZE(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [0:31];
    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_waddr = '0;

    always @(posedge bus.mem_re) begin
        re_cnt = re_cnt + 1;
        #1;
        bus.mem_rdata = ram[bus.mem_addr[4:0]];
    end

    always @(posedge bus.mem_we) begin
        we_cnt = we_cnt + 1;
        #1;
        last_wdata = bus.mem_wdata;
        last_waddr = bus.mem_addr;
        ram[bus.mem_addr[4:0]] = bus.mem_wdata;
    end

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int dre, output int dwe);
        int re0, we0;
        re0 = re_cnt;
        we0 = we_cnt;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        @(posedge clk); #1;
        // scramble inputs while busy; the unit must work from latched fields
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_size     = 2'b10;
        bus.req_unsigned = ~uns;
        bus.req_addr     = 32'h0000_0000;
        bus.req_wdata    = 32'hFFFF_FFFF;
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat = lat + 1;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(posedge clk); #1;
        dre = re_cnt - re0;
        dwe = we_cnt - we0;
    endtask

    int          lat, dre, dwe;
    logic [31:0] rdata;
    logic        err;
    logic        any_rv;

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(bus.req_ready),  32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err",   32'(bus.resp_err),   32'd0);
        check("rst_resp_rdata", bus.resp_rdata,      32'd0);
        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check("rst_mem_re",     32'(bus.mem_re),     32'd0);
        check("rst_mem_addr",   bus.mem_addr,        32'd0);
        check("rst_mem_wdata",  bus.mem_wdata,       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // abort a load while it sits in RD
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h0; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_in_rd_mem_re", 32'(bus.mem_re), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_mem_re",    32'(bus.mem_re),    32'd0);
        any_rv = bus.resp_valid;
        repeat (4) begin
            @(posedge clk); #1;
            any_rv = any_rv | bus.resp_valid;
        end
        check("abort_no_resp", 32'(any_rv), 32'd0);

        // store word then load it back
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat, rdata, err, dre, dwe);
        check("sw_lat",   32'(lat), 32'd2);
        check("sw_we",    32'(dwe), 32'd1);
        check("sw_re",    32'(dre), 32'd0);
        check("sw_waddr", last_waddr, 32'd2);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        check("sw_err",   32'(err), 32'd0);
        check("sw_rdata", rdata, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rdata, err, dre, dwe);
        check("lw_lat",   32'(lat), 32'd2);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_err",   32'(err), 32'd0);
        check("lw_re",    32'(dre), 32'd1);

        // byte store via read-modify-write
        do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h1234565A, lat, rdata, err, dre, dwe);
        check("sb_lat",   32'(lat), 32'd3);
        check("sb_wdata", last_wdata, 32'hDEAD5AEF);
        check("sb_re",    32'(dre), 32'd1);
        check("sb_we",    32'(dwe), 32'd1);
        check("sb_err",   32'(err), 32'd0);

        // sub-word loads with extension
        do_req(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, lat, rdata, err, dre, dwe);
        check("lb_b_signed", rdata, 32'hFFFFFFDE);
        do_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, lat, rdata, err, dre, dwe);
        check("lbu_b", rdata, 32'h000000DE);
        do_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, lat, rdata, err, dre, dwe);
        check("lh_a_signed", rdata, 32'hFFFFDEAD);
        do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, lat, rdata, err, dre, dwe);
        check("lb_9_positive", rdata, 32'h0000005A);
        do_req(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, lat, rdata, err, dre, dwe);
        check("lhu_8", rdata, 32'h00005AEF);

        // last valid word and an upper-half halfword RMW
        do_req(1'b1, 2'b10, 1'b0, 32'h7C, 32'h0BADF00D, lat, rdata, err, dre, dwe);
        check("sw_top_err", 32'(err), 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 32'h7E, 32'h0000CAFE, lat, rdata, err, dre, dwe);
        check("sh_top_lat",   32'(lat), 32'd3);
        check("sh_top_wdata", last_wdata, 32'hCAFEF00D);
        check("sh_top_waddr", last_waddr, 32'd31);

        // range and reserved-size errors
        do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat, rdata, err, dre, dwe);
        check("range_err",   32'(err), 32'd1);
        check("range_lat",   32'(lat), 32'd1);
        check("range_rdata", rdata, 32'd0);
        check("range_no_re", 32'(dre), 32'd0);
        check("range_no_we", 32'(dwe), 32'd0);
        do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'h0, lat, rdata, err, dre, dwe);
        check("rsvd_err",   32'(err), 32'd1);
        check("rsvd_lat",   32'(lat), 32'd1);
        check("rsvd_no_we", 32'(dwe), 32'd0);
        check("rsvd_no_re", 32'(dre), 32'd0);

        // misaligned word load
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, lat, rdata, err, dre, dwe);
        check("sw_w1_err", 32'(err), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat, rdata, err, dre, dwe);
        check("mis_mem_addr", bus.mem_addr, 32'd1);
`ifdef LSU_ALIGN_CHECK_EN
        check("mis_err",   32'(err), 32'd1);
        check("mis_lat",   32'(lat), 32'd1);
        check("mis_no_re", 32'(dre), 32'd0);
        check("mis_rdata", rdata, 32'd0);
`else
        check("mis_err",   32'(err), 32'd0);
        check("mis_lat",   32'(lat), 32'd2);
        check("mis_re",    32'(dre), 32'd1);
        check("mis_rdata", rdata, 32'h11223344);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
